devolve_troco: RTL

- Change dispenser for the vending machine; the payout counterpart of the coin summing path.
- Coin summing accumulates inserted value. This block does the reverse: it takes a change amount in coin units and pays it out coin by coin to a hopper.
- Uses a greedy largest-first denomination choice and a 4-phase req/ack handshake per coin.
- Runs on the 700 Hz system clock. It is started by the main state machine after a bebida is delivered.

---
 rtl/devolve_troco.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/devolve_troco.sv
// devolve_troco: change dispenser for the vending machine.
// Pays a change amount (in 0.25 units) to the coin hopper one coin at a time,
// always choosing the largest denomination that still fits, and uses a
// 4-phase req/ack handshake with a per-phase timeout.
// Optional build macro TROCO_ESTOQUE_EN adds per-denomination stock tracking
// and the abastecer refill input.
module devolve_troco #(
    parameter int TIMEOUT_CICLOS = 1400,
    parameter int LARGURA        = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               iniciar,
    input  logic [LARGURA-1:0] troco,
    input  logic               hopper_ack,
`ifdef TROCO_ESTOQUE_EN
    input  logic               abastecer,
`endif
    output logic               moeda_req,
    output logic [1:0]         moeda_sel,
    output logic [LARGURA-1:0] restante,
    output logic               ocupado,
    output logic               concluido,
    output logic               erro
);

    localparam int TIMER_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        CALCULA,
        PEDE,
        LIBERA,
        FIM,
        ERRO
    } estado_t;

    estado_t              estado_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 moeda_req_q;
    logic [1:0]           moeda_sel_q;
    logic [LARGURA-1:0]   restante_q;
    logic                 ocupado_q;
    logic                 concluido_q;
    logic                 erro_q;

    logic [2:0]           elegivel;     // {4-unit, 2-unit, 1-unit} coin available
    logic [1:0]           sel_d;
    logic [LARGURA-1:0]   restante_d;

    // Value in coin units of a denomination code.
    function automatic logic [LARGURA-1:0] coin_value(input logic [1:0] sel);
        logic [LARGURA-1:0] v;
        case (sel)
            2'b11:   v = LARGURA'(4);
            2'b10:   v = LARGURA'(2);
            2'b01:   v = LARGURA'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Greedy choice: largest eligible coin not exceeding the amount owed.
    // Returns 2'b00 when nothing fits, which keeps restante from underflowing.
    function automatic logic [1:0] pick_coin(input logic [LARGURA-1:0] r,
                                             input logic [2:0]         ok);
        logic [1:0] s;
        if (r >= LARGURA'(4) && ok[2])      s = 2'b11;
        else if (r >= LARGURA'(2) && ok[1]) s = 2'b10;
        else if (r >= LARGURA'(1) && ok[0]) s = 2'b01;
        else                                s = 2'b00;
        return s;
    endfunction

    assign sel_d      = pick_coin(restante_q, elegivel);
    assign restante_d = restante_q - coin_value(moeda_sel_q);

`ifdef TROCO_ESTOQUE_EN
    logic [2:0][3:0] estoque_q;
    logic [1:0]      estoque_idx;

    assign estoque_idx = moeda_sel_q - 2'd1;
    assign elegivel    = {|estoque_q[2], |estoque_q[1], |estoque_q[0]};

    // Stock bookkeeping: refill wins over the decrement of an accepted coin.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estoque_q <= {3{4'd15}};
        end else if (abastecer) begin
            estoque_q <= {3{4'd15}};
        end else if (estado_q == PEDE && hopper_ack && estoque_q[estoque_idx] != 4'd0) begin
            estoque_q[estoque_idx] <= estoque_q[estoque_idx] - 4'd1;
        end
    end
`else
    assign elegivel = 3'b111;
`endif

    // Payout state machine; every output is a register updated here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q    <= OCIOSO;
            timer_q     <= '0;
            moeda_req_q <= 1'b0;
            moeda_sel_q <= 2'b00;
            restante_q  <= '0;
            ocupado_q   <= 1'b0;
            concluido_q <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            concluido_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    timer_q <= '0;
                    if (iniciar) begin
                        restante_q <= troco;
                        erro_q     <= 1'b0;
                        ocupado_q  <= 1'b1;
                        estado_q   <= CALCULA;
                    end
                end
                CALCULA: begin
                    timer_q <= '0;
                    if (restante_q == '0) begin
                        concluido_q <= 1'b1;
                        estado_q    <= FIM;
                    end else if (sel_d == 2'b00) begin
                        // Only reachable with stock tracking: owed but no coin fits.
                        moeda_sel_q <= 2'b00;
                        ocupado_q   <= 1'b0;
                        erro_q      <= 1'b1;
                        estado_q    <= ERRO;
                    end else begin
                        moeda_sel_q <= sel_d;
                        moeda_req_q <= 1'b1;
                        estado_q    <= PEDE;
                    end
                end
                PEDE: begin
                    // An ack already high on entry is accepted; no edge detection.
                    if (hopper_ack) begin
                        restante_q  <= restante_d;
                        moeda_req_q <= 1'b0;
                        timer_q     <= '0;
                        estado_q    <= LIBERA;
                    end else if (timer_q == TIMER_MAX) begin
                        moeda_req_q <= 1'b0;
                        moeda_sel_q <= 2'b00;
                        ocupado_q   <= 1'b0;
                        erro_q      <= 1'b1;
                        timer_q     <= '0;
                        estado_q    <= ERRO;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                LIBERA: begin
                    // moeda_sel is held here until the hopper drops ack.
                    if (!hopper_ack) begin
                        timer_q  <= '0;
                        estado_q <= CALCULA;
                    end else if (timer_q == TIMER_MAX) begin
                        moeda_sel_q <= 2'b00;
                        ocupado_q   <= 1'b0;
                        erro_q      <= 1'b1;
                        timer_q     <= '0;
                        estado_q    <= ERRO;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                FIM: begin
                    timer_q     <= '0;
                    ocupado_q   <= 1'b0;
                    moeda_sel_q <= 2'b00;
                    estado_q    <= OCIOSO;
                end
                ERRO: begin
                    // restante stays frozen at the amount still owed.
                    timer_q <= '0;
                    if (iniciar) begin
                        erro_q     <= 1'b0;
                        restante_q <= troco;
                        ocupado_q  <= 1'b1;
                        estado_q   <= CALCULA;
                    end
                end
                default: begin
                    timer_q  <= '0;
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign moeda_req = moeda_req_q;
    assign moeda_sel = moeda_sel_q;
    assign restante  = restante_q;
    assign ocupado   = ocupado_q;
    assign concluido = concluido_q;
    assign erro      = erro_q;

endmodule
